stream_arbiter: RTL and testbench

- Parametrised successor to the two-input C-generated arbiter.
- Merges CHANNELS stb/ack input streams of WIDTH bits onto one stb/ack output stream.
- Selectable round-robin or fixed-priority arbitration; each output word is tagged with its source channel index.
- Sits between multiple producer processes and a single consumer process, all on one clock.

---
 rtl/stream_arbiter.sv | 126 ++++++++++++
 tb/tb_stream_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/stream_arbiter.sv
// Merges CHANNELS stb/ack input streams onto one tagged stb/ack output stream.
// Round-robin (MODE 0) or fixed lowest-index priority (MODE 1), one word in flight.
module stream_arbiter #(
   parameter int WIDTH    = 16,
   parameter int CHANNELS = 4,
   parameter int CH_BITS  = 2,
   parameter int MODE     = 0
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [CHANNELS*WIDTH-1:0] input_data,
   input  logic [CHANNELS-1:0]       input_stb,
   output logic [CHANNELS-1:0]       input_ack,
   output logic [WIDTH-1:0]          output_z,
   output logic [CH_BITS-1:0]        output_z_channel,
   output logic                      output_z_stb,
   input  logic                      output_z_ack
);

   localparam logic [1:0] ARBITRATE = 2'd0;
   localparam logic [1:0] ACCEPT    = 2'd1;
   localparam logic [1:0] SEND      = 2'd2;

   logic [1:0]          state_q, state_d;
   logic [CH_BITS-1:0]  grant_q, grant_d;
   logic [CH_BITS-1:0]  last_q, last_d;
   logic [CHANNELS-1:0] ack_q, ack_d;
   logic [WIDTH-1:0]    z_q, z_d;
   logic [CH_BITS-1:0]  zch_q, zch_d;
   logic                zstb_q, zstb_d;

   logic [CH_BITS-1:0]  sel;
   logic                found;
   logic [WIDTH-1:0]    cur_data;

   // Candidate k is last+1+k modulo CHANNELS; since last < CHANNELS one subtraction wraps it.
   always_comb begin
      int idx;
      logic [CH_BITS-1:0] cand;
      idx   = 0;
      cand  = '0;
      sel   = '0;
      found = 1'b0;
      for (int k = 0; k < CHANNELS; k++) begin
         if (MODE == 1) begin
            idx = k;
         end else begin
            idx = int'(last_q) + 1 + k;
            if (idx >= CHANNELS) idx = idx - CHANNELS;
         end
         cand = CH_BITS'(idx);
         if (!found && input_stb[cand]) begin
            found = 1'b1;
            sel   = cand;
         end
      end
   end

   assign cur_data = input_data[int'(grant_q)*WIDTH +: WIDTH];

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      ack_d   = ack_q;
      z_d     = z_q;
      zch_d   = zch_q;
      zstb_d  = zstb_q;
      case (state_q)
         ARBITRATE: begin
            if (found) begin
               grant_d = sel;
               ack_d   = CHANNELS'(1) << sel;
               state_d = ACCEPT;
            end
         end
         ACCEPT: begin
            if (input_stb[grant_q] && ack_q[grant_q]) begin
               z_d     = cur_data;
               zch_d   = grant_q;
               ack_d   = '0;
               zstb_d  = 1'b1;
               state_d = SEND;
            end
         end
         SEND: begin
            if (output_z_ack) begin
               zstb_d  = 1'b0;
               last_d  = grant_q;
               state_d = ARBITRATE;
            end
         end
         default: begin
            ack_d   = '0;
            zstb_d  = 1'b0;
            state_d = ARBITRATE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ARBITRATE;
         grant_q <= '0;
         last_q  <= CH_BITS'(CHANNELS - 1);
         ack_q   <= '0;
         z_q     <= '0;
         zch_q   <= '0;
         zstb_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         ack_q   <= ack_d;
         z_q     <= z_d;
         zch_q   <= zch_d;
         zstb_q  <= zstb_d;
      end
   end

   assign input_ack        = ack_q;
   assign output_z         = z_q;
   assign output_z_channel = zch_q;
   assign output_z_stb     = zstb_q;

endmodule

// File: tb/tb_stream_arbiter.sv
// Bench for stream_arbiter: instance 0 round-robin, instance 1 fixed priority.
// Queued source models feed each instance; a scoreboard checks every output word.
module tb_stream_arbiter;

   localparam int W  = 16;
   localparam int C  = 4;
   localparam int CB = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic [C*W-1:0] din  [2];
   logic [C-1:0]   stb  [2];
   logic [C-1:0]   ack  [2];
   logic [W-1:0]   z    [2];
   logic [CB-1:0]  zch  [2];
   logic           zstb [2];
   logic           zack [2];

   logic [15:0]    mem   [2][C][32];
   int             hd    [2][C];
   int             tl    [2][C];
   logic           pause [2][C];

   logic [17:0]    expq0[$];
   logic [17:0]    expq1[$];
   int             tq0[$];
   int             cyc = 0;
   int             nvec = 0;
   int             nerr = 0;
   int             hot_viol = 0;
   int             prio_viol = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      if (obs !== exp) begin
         nerr++;
         $display("FAIL %s: got %h want %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   for (genvar gd = 0; gd < 2; gd++) begin : g_dut
      stream_arbiter #(.WIDTH(W), .CHANNELS(C), .CH_BITS(CB), .MODE(gd)) u_dut (
         .clk              (clk),
         .rst              (rst),
         .input_data       (din[gd]),
         .input_stb        (stb[gd]),
         .input_ack        (ack[gd]),
         .output_z         (z[gd]),
         .output_z_channel (zch[gd]),
         .output_z_stb     (zstb[gd]),
         .output_z_ack     (zack[gd])
      );

      // Source: presents the queue head, pops it on the edge after a handshake.
      initial begin
         bit xf [C];
         stb[gd] = '0;
         din[gd] = '0;
         for (int c = 0; c < C; c++) xf[c] = 1'b0;
         forever begin
            @(posedge clk); #1;
            for (int c = 0; c < C; c++) if (xf[c]) hd[gd][c]++;
            for (int c = 0; c < C; c++) begin
               stb[gd][c] = (hd[gd][c] != tl[gd][c]) && !pause[gd][c];
               din[gd][c*W +: W] = (hd[gd][c] != tl[gd][c]) ? mem[gd][c][hd[gd][c]] : '0;
            end
            @(negedge clk); #1;
            for (int c = 0; c < C; c++) begin
               stb[gd][c] = (hd[gd][c] != tl[gd][c]) && !pause[gd][c];
               din[gd][c*W +: W] = (hd[gd][c] != tl[gd][c]) ? mem[gd][c][hd[gd][c]] : '0;
            end
            #1;
            for (int c = 0; c < C; c++) xf[c] = stb[gd][c] & ack[gd][c];
         end
      end

      always @(negedge clk) begin
         logic [17:0] e;
         #2;
         if (!$onehot0(ack[gd])) hot_viol++;
         if (zstb[gd] && zack[gd]) begin
            e = 18'h3DEAD;
            if (gd == 0) begin
               if (expq0.size() > 0) e = expq0.pop_front();
               tq0.push_back(cyc);
            end else begin
               if (expq1.size() > 0) e = expq1.pop_front();
            end
            chk($sformatf("out%0d", gd), 32'({zch[gd], z[gd]}), 32'(e));
         end
      end
   end

   always @(negedge clk) begin
      #2;
      if (stb[1][0] && (ack[1][C-1:1] != '0)) prio_viol++;
   end

   task automatic push(input int d, input int c, input logic [15:0] w, input bit exp_out);
      logic [17:0] e;
      mem[d][c][tl[d][c]] = w;
      tl[d][c]++;
      e = {CB'(c), w};
      if (exp_out) begin
         if (d == 0) expq0.push_back(e);
         else        expq1.push_back(e);
      end
   endtask

   task automatic drain(input int d);
      bit busy;
      busy = 1'b1;
      for (int i = 0; i < 300 && busy; i++) begin
         @(negedge clk);
         busy = zstb[d] || ((d == 0) ? (expq0.size() != 0) : (expq1.size() != 0));
         for (int c = 0; c < C; c++) if (hd[d][c] != tl[d][c]) busy = 1'b1;
      end
      chk($sformatf("drain%0d", d), 32'(busy), 32'd0);
   endtask

   task automatic wait_zstb(input int d);
      for (int i = 0; i < 50 && !zstb[d]; i++) @(negedge clk);
      chk("wait_zstb", 32'(zstb[d]), 32'd1);
   endtask

   task automatic pulse_rst();
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      zack[0] = 1'b0;
      zack[1] = 1'b0;
      for (int d = 0; d < 2; d++)
         for (int c = 0; c < C; c++) pause[d][c] = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst0", 32'({ack[0], zstb[0], zch[0], z[0]}), 32'd0);
      chk("rst1", 32'({ack[1], zstb[1], zch[1], z[1]}), 32'd0);
      rst = 1'b0;

      // Single request on channel 2, second word queued behind it.
      zack[0] = 1'b1;
      @(negedge clk);
      tq0.delete();
      push(0, 2, 16'h1234, 1);
      push(0, 2, 16'h4321, 1);
      chk("t1_ack0", 32'(ack[0]), 32'd0);
      @(negedge clk);
      chk("t1_ack", 32'({ack[0], zstb[0]}), 32'b0100_0);
      @(negedge clk);
      chk("t1_stb", 32'({ack[0], zstb[0]}), 32'b0000_1);
      @(negedge clk);
      chk("t1_stb_off", 32'(zstb[0]), 32'd0);
      drain(0);
      chk("t1_gap", 32'(tq0[1] - tq0[0]), 32'd3);

      // Fairness: all channels request from reset, order 0,1,2,3,0,1,2,3.
      pulse_rst();
      tq0.delete();
      for (int r = 0; r < 2; r++)
         for (int c = 0; c < C; c++) push(0, c, 16'hA000 + 16'(c), 1);
      drain(0);
      chk("t2_n", 32'(tq0.size()), 32'd8);
      chk("t2_rate", 32'(tq0[7] - tq0[0]), 32'd21);

      // Fixed priority: channel 0 always wins while requesting.
      zack[1] = 1'b1;
      @(negedge clk);
      for (int c = 0; c < C; c++)
         for (int r = 0; r < 3; r++) push(1, c, 16'hA000 + 16'(c), 1);
      drain(1);
      chk("t3_prio", 32'(prio_viol), 32'd0);

      // Back-pressure with wrap-around: last=3, channels 3 and 0 request.
      zack[0] = 1'b0;
      push(0, 0, 16'h0C0C, 1);
      push(0, 3, 16'h3333, 1);
      wait_zstb(0);
      for (int i = 0; i < 10; i++) begin
         chk("t4_hold", 32'({ack[0], zstb[0], zch[0], z[0]}), 32'({4'b0, 1'b1, 2'd0, 16'h0C0C}));
         @(negedge clk);
      end
      zack[0] = 1'b1;
      drain(0);

      // Reset while a word is waiting in SEND: the word is dropped.
      zack[0] = 1'b0;
      push(0, 1, 16'h5555, 0);
      wait_zstb(0);
      rst = 1'b1;
      @(negedge clk);
      chk("t5_rst", 32'({ack[0], zstb[0], zch[0], z[0]}), 32'd0);
      rst = 1'b0;
      zack[0] = 1'b1;
      for (int c = 0; c < C; c++) push(0, c, 16'h6000 + 16'(c), 1);
      drain(0);

      // Stalled source: channel 1 granted, then drops stb for 5 cycles.
      push(0, 1, 16'h00FF, 1);
      for (int i = 0; i < 50 && !ack[0][1]; i++) @(negedge clk);
      chk("t6_grant", 32'(ack[0]), 32'b0010);
      pause[0][1] = 1'b1;
      push(0, 2, 16'h2222, 1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("t6_stall", 32'({ack[0], zstb[0]}), 32'b0010_0);
      end
      pause[0][1] = 1'b0;
      drain(0);

      chk("onehot", 32'(hot_viol), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
